iir_decim_out_buf: RTL
======================

Name: iir_decim_out_buf

Overview:
Output stage placed directly downstream of the 16-bit biquad IIR filter. It consumes one filtered sample per in_valid strobe and block-averages DECIM consecutive samples, giving decimation by DECIM. Each averaged result is buffered in a small first-word-fall-through FIFO and handed to the consumer over a valid/ready handshake. The block reports FIFO occupancy and keeps a sticky overflow flag for dropped results.

Parameters:
DATA_BIT_NUM, 16, sample width; signed two's complement on both input and output.
LOG2_DECIM, 2, log2 of the decimation factor; legal range 1..4.
DECIM, 2**LOG2_DECIM, decimation factor; derived, must not be overridden.
ADDR_W, 2, FIFO address width; FIFO depth is 2**ADDR_W entries.

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous, active-low.
in_valid  in  1  a filter output sample is present on data_in this cycle.
data_in  in  DATA_BIT_NUM signed  filter output sample.
clear  in  1  synchronous flush of the accumulator, FIFO and overflow flag.
out_valid  out  1  FIFO is non-empty; data_out is valid.
out_ready  in  1  consumer accepts data_out this cycle.
data_out  out  DATA_BIT_NUM signed  oldest buffered result.
fifo_level  out  ADDR_W+1  number of entries in the FIFO, 0..2**ADDR_W.
overflow  out  1  sticky flag: a result was dropped because the FIFO was full.
ovf_clr  in  1  synchronous clear of overflow.

Behaviour:
- Reset, asynchronous and active-low: phase=0, acc=0, rd_ptr=wr_ptr=0, fifo_level=0, overflow=0.
- Output values during reset: out_valid=0, data_out=0.
- A reset asserted mid-frame discards the partial accumulation and all FIFO contents.
- Accumulator: signed, DATA_BIT_NUM+LOG2_DECIM bits wide, so it cannot overflow.
- Phase counter runs 0..DECIM-1 and advances only on in_valid. It wraps from DECIM-1 to 0.
- On in_valid with phase==0: acc <= sign-extended data_in.
- On in_valid with 0<phase<DECIM-1: acc <= acc + data_in.
- On in_valid with phase==DECIM-1 (completion):
  - sum = acc + data_in.
  - result = sum >>> LOG2_DECIM, an arithmetic shift that rounds toward minus infinity.
  - result always fits in DATA_BIT_NUM bits; no saturation is needed.
  - result is pushed into the FIFO on the same clock edge.
- When in_valid=0, phase and acc hold their values.
- Latency: out_valid rises in the cycle after the clock edge that samples the completing in_valid, provided the FIFO was empty.
- The FIFO is first-word-fall-through:
  - data_out = mem[rd_ptr] while fifo_level>0.
  - data_out = 0 when the FIFO is empty.
  - out_valid = (fifo_level != 0).
- Pop happens when out_valid && out_ready: rd_ptr increments.
- out_ready while the FIFO is empty has no effect.
- Push and pop in the same cycle: both take effect and fifo_level is unchanged. This holds when the FIFO is full: the push is accepted because the pop frees a slot.
- Push while full with no pop: the result is dropped, pointers are unchanged, and overflow <= 1.
- Pointers are ADDR_W bits and wrap modulo the depth. fifo_level is tracked in a separate counter.
- overflow stays set until ovf_clr or clear.
  - If a drop occurs in the same cycle as ovf_clr, set wins and overflow stays 1.
- clear empties the FIFO, sets phase=0 and acc=0, and clears overflow.
  - clear takes priority over in_valid and over a pop in the same cycle; a sample arriving that cycle is ignored.
- data_out must not change while out_valid=1 and out_ready=0.

Test Plan:
1. LOG2_DECIM=2, out_ready=1, in_valid on data_in 100,200,300,400 -> one result of 250; out_valid high for exactly one cycle, starting one cycle after the 4th in_valid edge.
2. Inputs -1,-2,-3,-4 -> result -3 (sum -10 >>> 2). Inputs 1,1,1,2 -> result 1.
3. Extremes: four samples of 32767 -> 32767. Four samples of -32768 -> -32768. No wrap in either case.
4. out_ready=0, 20 samples of 10*k (k=1..20) -> 5 completions. fifo_level=4 and overflow=1 (5th result dropped). Draining gives 25, 65, 105, 145 in order, then out_valid=0 and data_out=0.
5. FIFO full with out_ready=1 on the cycle a completion pushes -> fifo_level stays 4, overflow stays 0, next pop returns the new result in FIFO order. Repeat with ovf_clr and a drop in the same cycle -> overflow=1.
6. Feed 2 samples, pulse clear, then feed 8,8,8,8 -> single result 8. Also: assert rst_n=0 mid-frame with 2 entries buffered -> out_valid=0, fifo_level=0 immediately, and the next 4 samples produce a clean average.

Source files
------------

// File: rtl/iir_decim_out_buf.sv
// Decimating output stage for the biquad IIR: block-averages DECIM samples and
// buffers each result in a small FWFT FIFO with a valid/ready consumer port.
module iir_decim_out_buf #(
  parameter int DATA_BIT_NUM = 16,
  parameter int LOG2_DECIM   = 2,
  parameter int DECIM        = 2**LOG2_DECIM,
  parameter int ADDR_W       = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic signed [DATA_BIT_NUM-1:0] data_in,
  input  logic                           clear,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [DATA_BIT_NUM-1:0] data_out,
  output logic [ADDR_W:0]                fifo_level,
  output logic                           overflow,
  input  logic                           ovf_clr
);
  localparam int AW    = DATA_BIT_NUM + LOG2_DECIM;
  localparam int DEPTH = 2**ADDR_W;

  logic [LOG2_DECIM-1:0]          phase_q, phase_d;
  logic signed [AW-1:0]           acc_q, acc_d;
  logic [ADDR_W-1:0]              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]                level_q, level_d;
  logic                           ovf_q, ovf_d;
  logic signed [DATA_BIT_NUM-1:0] mem_q [DEPTH];

  logic signed [AW-1:0]           din_ext, sum_w;
  logic signed [DATA_BIT_NUM-1:0] result;
  logic                           complete, full, pop, push, drop;

  assign din_ext  = {{LOG2_DECIM{data_in[DATA_BIT_NUM-1]}}, data_in};
  assign sum_w    = acc_q + din_ext;
  // Accumulator has LOG2_DECIM guard bits, so the shifted mean always fits.
  assign result   = DATA_BIT_NUM'(sum_w >>> LOG2_DECIM);
  assign complete = in_valid && !clear && (phase_q == LOG2_DECIM'(DECIM-1));
  assign full     = (level_q == (ADDR_W+1)'(DEPTH));
  assign pop      = out_valid && out_ready && !clear;
  assign push     = complete && (!full || pop);
  assign drop     = complete && full && !pop;

  assign out_valid  = (level_q != '0);
  assign data_out   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;

  always_comb begin
    phase_d  = phase_q;
    acc_d    = acc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (clear) begin
      phase_d  = '0;
      acc_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (in_valid) begin
        phase_d = phase_q + LOG2_DECIM'(1);
        acc_d   = (phase_q == '0) ? din_ext : sum_w;
      end
      if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + (ADDR_W+1)'(1);
        2'b01:   level_d = level_q - (ADDR_W+1)'(1);
        default: level_d = level_q;
      endcase
      // A drop in the same cycle as ovf_clr keeps the flag set.
      if (drop)         ovf_d = 1'b1;
      else if (ovf_clr) ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= '0;
      acc_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      acc_q    <= acc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: reads are masked while the level is zero.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= result;
  end
endmodule
